apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Upstream APB requester that feeds the UART APB slave port.
- Converts a simple valid/ready command stream (CPU model, DMA or test sequencer) into APB4 SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response stream.
- Handles one outstanding transfer at a time, wait states, PSLVERR and a watchdog timeout for a stuck PREADY.

Parameters:
- ADDR_WIDTH, 12, width of req_addr and paddr (UART register map is 12-bit).
- DATA_WIDTH, 32, width of data buses; must be 32.
- TIMEOUT_CYCLES, 256, consecutive ACCESS cycles with pready=0 before abort; 0 disables the timeout.

Ports:
- pclk  in  1  system clock, all logic on rising edge.
- preset  in  1  synchronous reset, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  bridge can accept a command.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  target byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborted transfers.
- rsp_err  out  1  pslverr sampled, or timeout abort.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  4  APB strobes.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (preset=1 at an edge):
  - State IDLE.
  - All outputs 0 except req_ready=1.
  - Timeout counter cleared.
- Reset during any state:
  - psel and penable are 0 after that edge.
  - Any in-flight transfer and pending response are discarded; no rsp_valid is produced.
- All APB outputs and rsp_* are registered. No combinational path from APB inputs to any output.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch write, addr, wdata, strb; go to SETUP.
- SETUP (one cycle):
  - psel=1, penable=0.
  - paddr and pwrite come from the latched command.
  - Writes: pwdata=wdata, pstrb=strb.
  - Reads: pwdata=0, pstrb=0.
  - req_ready=0.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite, pwdata and pstrb are held stable.
  - On an edge with pready=1:
    - rsp_rdata = prdata for reads, 0 for writes.
    - rsp_err = pslverr.
    - psel=0, penable=0, rsp_valid=1; go to RESP.
  - On an edge with pready=0: increment the timeout counter.
  - When TIMEOUT_CYCLES is nonzero and the counter reaches TIMEOUT_CYCLES:
    - Abort: psel=0, penable=0, rsp_err=1, rsp_rdata=0, rsp_valid=1; go to RESP.
  - The counter clears on entry to SETUP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1 at an edge.
  - On that edge: go to IDLE, rsp_valid=0, req_ready=1.
- Latency with zero wait states:
  - Accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid high after edge N+2.
  - Each APB wait state adds 1 cycle.
  - Minimum spacing between accepted commands is 4 cycles.
- Simultaneous events:
  - pready=1 on the same edge the timeout would fire: pready wins, a normal response is produced.
  - req_valid while not IDLE: ignored; the requester must hold the command until req_ready.
- pslverr is sampled only in ACCESS with pready=1.

Test Plan:
- Write with zero wait states: req write addr 0x000, wdata 0xA5A5A5A5, strb 0x1 -> psel rises 1 cycle after accept and penable 1 cycle after that. During ACCESS: paddr=0x000, pwdata=0xA5A5A5A5, pstrb=0x1. rsp_valid 2 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states (slave model returns 0x000000A5 at 0x000) -> ACCESS lasts 4 cycles, pstrb=0, rsp_rdata=0x000000A5, rsp_err=0, rsp_valid 5 cycles after accept.
- Slave error: read addr 0x004, slave returns pready=1 with pslverr=1 -> rsp_err=1, psel=0 next cycle, bridge returns to IDLE after rsp_ready.
- Timeout with TIMEOUT_CYCLES=4: pready held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0. A later command completes normally.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0 throughout. Accept occurs the cycle after rsp_ready rises.
- Reset mid-ACCESS: preset=1 during a waited read -> psel=0, penable=0, rsp_valid=0, req_ready=1 after the edge. No stale response after reset is released.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Signal bundle for apb_master_bridge: command stream, response stream and APB4 requester bus.
// Both streams use valid/ready: a beat transfers on a rising edge where valid and ready are both 1,
// and the sender holds valid and its payload unchanged until that edge.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [3:0]            req_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [3:0]            pstrb;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    // Bridge view.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    // Environment view: requester, response consumer and APB completer.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns one valid/ready command into a SETUP/ACCESS transfer and returns
// read data plus error status; a stuck PREADY is aborted after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                pclk,
    input  logic                preset,
    apb_master_bridge_if.master bus,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT_CYCLES-1: the edge that would make it TIMEOUT_CYCLES aborts.
    localparam int               CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic [3:0]            pstrb_q,     pstrb_d;

    assign timeout_hit = TIMEOUT_EN && (state == S_ACCESS) && !bus.pready && (wait_cnt == CNT_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.req_valid) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (bus.pready || timeout_hit) state_nxt = S_RESP;
            S_RESP:   if (bus.rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the APB command fields are loaded once at accept
    // and simply held through SETUP and ACCESS.
    always_comb begin
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready_d = (state_nxt == S_IDLE);
        psel_d      = (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
        penable_d   = (state_nxt == S_ACCESS);
        rsp_valid_d = (state_nxt == S_RESP);
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    paddr_d  = bus.req_addr;
                    pwrite_d = bus.req_write;
                    pwdata_d = bus.req_write ? bus.req_wdata : '0;
                    pstrb_d  = bus.req_write ? bus.req_strb  : 4'h0;
                end
            end
            S_ACCESS: begin
                if (bus.pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d   = bus.pslverr;
                end else if (timeout_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= 4'h0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    // Counts ACCESS edges without PREADY; cleared while idle so every transfer starts from zero.
    always_ff @(posedge pclk) begin
        if (preset || state == S_IDLE) begin
            wait_cnt <= '0;
        end else if (state == S_ACCESS && !bus.pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.paddr     = paddr_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model of the bridge timing and a word memory
// behind a scripted APB completer, checked against the DUT on every cycle.
module tb_apb_master_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic       pclk = 1'b0;
    logic       preset;
    logic [1:0] fsm_state;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .bus(bus),
        .fsm_state(fsm_state)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_err    = 0;

    // Model of one transfer: k edges since accept; psel for k<=L, penable for 1<=k<=L,
    // response from k=L+1 until the rsp handshake. L = waits+1, or TO when the completer stalls.
    bit              model_live = 1'b0;
    bit              m_busy     = 1'b0;
    int              m_k, m_L;
    bit              m_to, m_err, m_write;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [3:0]      m_strb;
    logic [DW-1:0]   exp_rdata;
    bit              exp_err;
    logic [DW-1:0]   mem [16] = '{default: '0};
    int              plan_w   = 0;
    bit              plan_err = 1'b0;

    int              r_lat, r_nv, r_psel, r_pen;
    logic [DW-1:0]   r_rd;
    logic            r_re;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge pclk) begin
        if (preset) begin
            m_busy     = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (!m_busy) begin
                if (bus.req_valid) begin
                    m_busy  = 1'b1;
                    m_k     = 0;
                    m_write = bus.req_write;
                    m_addr  = bus.req_addr;
                    m_wdata = bus.req_wdata;
                    m_strb  = bus.req_strb;
                    m_err   = plan_err;
                    m_to    = (TO != 0) && (plan_w >= TO);
                    m_L     = m_to ? TO : plan_w + 1;
                end
            end else if ((m_k >= m_L + 1) && bus.rsp_ready) begin
                m_busy = 1'b0;
            end else begin
                m_k++;
                if (m_k == m_L + 1) begin
                    if (m_to) begin
                        exp_rdata = '0;
                        exp_err   = 1'b1;
                    end else begin
                        exp_err   = m_err;
                        exp_rdata = m_write ? '0 : mem[m_addr[5:2]];
                        if (m_write && !m_err)
                            for (int b = 0; b < 4; b++)
                                if (m_strb[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // APB completer: answers on the planned ACCESS cycle, random noise everywhere else.
    always @(negedge pclk) begin
        if (m_busy && m_k >= 1 && m_k <= m_L) begin
            if (!m_to && m_k == m_L) begin
                bus.pready  = 1'b1;
                bus.pslverr = m_err;
                bus.prdata  = m_write ? DW'($urandom) : mem[m_addr[5:2]];
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'($urandom_range(0, 1));
                bus.prdata  = DW'($urandom);
            end
        end else begin
            bus.pready  = 1'($urandom_range(0, 1));
            bus.pslverr = 1'($urandom_range(0, 1));
            bus.prdata  = DW'($urandom);
        end
    end

    always @(negedge pclk) begin : compare_p
        bit e_psel, e_pen, e_rv;
        if (model_live) begin
            e_psel = m_busy && (m_k <= m_L);
            e_pen  = m_busy && (m_k >= 1) && (m_k <= m_L);
            e_rv   = m_busy && (m_k >= m_L + 1);
            chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
            chk("psel",      32'(bus.psel),      32'(e_psel));
            chk("penable",   32'(bus.penable),   32'(e_pen));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            if (e_psel) begin
                chk("paddr",  32'(bus.paddr),  32'(m_addr));
                chk("pwrite", 32'(bus.pwrite), 32'(m_write));
                chk("pwdata", bus.pwdata,      m_write ? m_wdata : 32'h0);
                chk("pstrb",  32'(bus.pstrb),  m_write ? 32'(m_strb) : 32'h0);
            end
            if (e_rv) begin
                chk("rsp_rdata", bus.rsp_rdata,    exp_rdata);
                chk("rsp_err",   32'(bus.rsp_err), 32'(exp_err));
            end
        end
    end

    task automatic do_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [3:0] st, input int w, input bit er,
                          input int hold, input int rst_k, input bit rnd);
        int guard;
        guard = 0;
        while (m_busy && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        plan_w        = w;
        plan_err      = er;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_strb  = st;
        bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge pclk);
        bus.req_valid = 1'b0;
        r_lat = -1; r_nv = 0; r_psel = -1; r_pen = -1; r_rd = '0; r_re = 1'b0;
        guard = 0;
        while (m_busy && guard < 100) begin
            if (bus.psel === 1'b1 && r_psel < 0) r_psel = guard;
            if (bus.penable === 1'b1 && r_pen < 0) r_pen = guard;
            if (bus.rsp_valid === 1'b1) begin
                r_nv++;
                if (r_lat < 0) begin
                    r_lat = guard;
                    r_rd  = bus.rsp_rdata;
                    r_re  = bus.rsp_err;
                end
            end
            if (rst_k >= 0 && guard == rst_k) begin
                preset        = 1'b1;
                bus.rsp_ready = 1'b0;
            end else if (rnd) begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_write = 1'($urandom_range(0, 1));
                bus.req_addr  = AW'($urandom);
                bus.req_wdata = DW'($urandom);
                bus.req_strb  = 4'($urandom);
            end else begin
                bus.rsp_ready = (r_lat >= 0) && (guard - r_lat >= hold);
            end
            @(negedge pclk);
            guard++;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        if (m_busy) begin
            n_checks++;
            n_err++;
            $display("FAIL txn_done: still busy after %0d cycles, expected completion", guard);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        preset        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = 4'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_psel",      32'(bus.psel),      32'd0);
        chk("rst_penable",   32'(bus.penable),   32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_paddr",     32'(bus.paddr),     32'd0);
        chk("rst_pwrite",    32'(bus.pwrite),    32'd0);
        chk("rst_pwdata",    bus.pwdata,         32'd0);
        chk("rst_pstrb",     32'(bus.pstrb),     32'd0);
        preset = 1'b0;
        @(negedge pclk);

        do_cmd(1'b1, 12'h000, 32'hA5A5_A5A5, 4'h1, 0, 1'b0, 0, -1, 1'b0);
        chk("wr0_psel_at",   32'(r_psel), 32'd0);
        chk("wr0_pen_at",    32'(r_pen),  32'd1);
        chk("wr0_latency",   32'(r_lat),  32'd2);
        chk("wr0_rdata",     r_rd,        32'd0);
        chk("wr0_err",       32'(r_re),   32'd0);

        do_cmd(1'b0, 12'h000, 32'h0, 4'h0, 3, 1'b0, 0, -1, 1'b0);
        chk("rd3w_pen_at",   32'(r_pen),  32'd1);
        chk("rd3w_latency",  32'(r_lat),  32'd5);
        chk("rd3w_rdata",    r_rd,        32'h0000_00A5);
        chk("rd3w_err",      32'(r_re),   32'd0);

        do_cmd(1'b0, 12'h004, 32'h0, 4'h0, 0, 1'b1, 0, -1, 1'b0);
        chk("slverr_latency", 32'(r_lat), 32'd2);
        chk("slverr_err",     32'(r_re),  32'd1);

        do_cmd(1'b0, 12'h008, 32'h0, 4'h0, 4, 1'b0, 0, -1, 1'b0);
        chk("timeout_latency", 32'(r_lat), 32'd5);
        chk("timeout_rdata",   r_rd,       32'd0);
        chk("timeout_err",     32'(r_re),  32'd1);

        do_cmd(1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 0, -1, 1'b0);
        chk("after_to_latency", 32'(r_lat), 32'd3);
        chk("after_to_err",     32'(r_re),  32'd0);

        do_cmd(1'b0, 12'h008, 32'h0, 4'h0, 0, 1'b0, 0, -1, 1'b0);
        chk("rdback_rdata", r_rd, 32'hDEAD_BEEF);

        do_cmd(1'b0, 12'h008, 32'h0, 4'h0, 0, 1'b0, 5, -1, 1'b0);
        chk("bp_valid_cycles", 32'(r_nv), 32'd6);
        chk("bp_rdata",        r_rd,      32'hDEAD_BEEF);
        chk("bp_ready_after",  32'(bus.req_ready), 32'd1);
        do_cmd(1'b1, 12'h00C, 32'h1234_5678, 4'h3, 0, 1'b0, 0, -1, 1'b0);
        chk("b2b_latency", 32'(r_lat), 32'd2);

        do_cmd(1'b0, 12'h00C, 32'h0, 4'h0, 3, 1'b0, 0, 2, 1'b0);
        chk("mid_rst_psel",      32'(bus.psel),      32'd0);
        chk("mid_rst_penable",   32'(bus.penable),   32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        preset = 1'b0;
        stale  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid !== 1'b0) stale++;
        end
        chk("no_stale_rsp", 32'(stale), 32'd0);

        for (int n = 0; n < 150; n++) begin
            do_cmd(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 4'($urandom),
                   $urandom_range(0, 5), ($urandom_range(0, 7) == 0), 0, -1, 1'b1);
        end
        repeat (3) @(negedge pclk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
